trash_sequencer: RTL and testbench
==================================

# trash_sequencer

Fetch/decode/execute controller for the trash CPU datapath. It owns the 8-word program store and the program counter. It sequences the shared register file, the 4-bit ALU and the 16-byte data memory, and drives the dedicated output. It sits between the top-level pin decoder, which supplies program words and run/load strobes, and the datapath blocks, which it drives through request/strobe signals.

## Interface
- No parameters; widths are fixed: 8 program words × 15 bits, 4 × 8-bit registers, 16 × 8-bit data memory.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- prog_valid  in  1  program word present this cycle (honoured only in LOAD)
- prog_data  in  15  program word
- run  in  1  start execution at pc=0
- load  in  1  abort anything, return to LOAD, load pointer := 0
- rf_raddr_a, rf_raddr_b  out  2 each  register read addresses
- rf_rdata_a, rf_rdata_b  in  8 each  combinational read data
- rf_we  out  1  register write strobe; rf_waddr out 2; rf_wdata out 8
- alu_start  out  1  one-cycle ALU request; alu_op out 4; alu_a, alu_b out 4 each
- alu_done  in  1  ALU result valid; alu_res in 8
- mem_we  out  1; mem_re out 1; mem_addr out 4; mem_wdata out 8; mem_rdata in 8 (valid the cycle after mem_re)
- out_valid  out  1  one-cycle pulse per OUT; out_data out 8 (held between OUTs)
- pc  out  3  current program counter; halted out 1 sticky HALT flag

## Operation
- Word fields: op=w[2:0], f1=w[6:3], f2=w[10:7], f3=w[14:11], imm=w[14:7]; register selects use the low 2 bits of their field.
- States: LOAD (reset state), FETCH, EXEC, ALU_WAIT, MEM_WB, HALT.
- LOAD: on each prog_valid, prog[lp] := prog_data and lp := lp+1 mod 8; a 9th word overwrites word 0. run → FETCH with pc := 0.
- FETCH: ir := prog[pc] → EXEC.
- EXEC, per op:
  - 0 NOOP: no datapath effect.
  - 1 STORE: rf[f1] := imm.
  - 2 CALC: alu_start=1, alu_op=f1, alu_a=rf[f2][7:4], alu_b=rf[f2][3:0] → ALU_WAIT.
  - 3 MEMSTORE: mem[f1] := imm.
  - 4 MEMLOAD: mem_re, mem_addr=f1 → MEM_WB.
  - 5 JUMP: pc := f1[2:0].
  - 6 JUMPIF: if rf[f2]==rf[f3] then pc := f1[2:0], else pc+1.
  - 7 OUT: out_data := rf[f1], out_valid pulse.
- Non-branch single-cycle ops set pc := pc+1 mod 8 (7 wraps to 0) → FETCH.
- ALU_WAIT: hold; on alu_done, rf[f3] := alu_res, pc+1 → FETCH. alu_done outside ALU_WAIT is ignored.
- MEM_WB: rf[f2] := mem_rdata, pc+1 → FETCH.
- JUMP or a taken JUMPIF whose target equals the current pc → HALT, halted := 1, pc unchanged. HALT is left only via load or reset.
- load has priority over run and over every state. It abandons any in-flight CALC or MEMLOAD with no register write and clears halted.
- run outside LOAD is ignored. prog_valid outside LOAD is ignored. Simultaneous prog_valid and run in LOAD: the word is written, then the block goes to FETCH.
- Program contents survive load/run cycles; reset clears only state, not prog[].

## Timing
- Reset values: state LOAD, pc=0, lp=0, halted=0, out_valid=0, out_data=0x00. rf_we, mem_we, mem_re and alu_start are 0; all address/data outputs are 0.
- Strobes (rf_we, mem_we, mem_re, alu_start) are combinational from state/ir and are high only during the EXEC, MEM_WB or ALU_WAIT-done cycle.
- out_valid and out_data are registered: they appear the cycle after OUT's EXEC.
- run sampled at edge N: FETCH during N..N+1, EXEC during N+1..N+2, commit at edge N+2.
- Latency per op: single-cycle ops take 2 cycles; MEMLOAD takes 3; CALC takes 3 + ALU wait cycles (alu_done in the cycle after alu_start gives 3).
- pc output updates at the commit edge.

## Test plan
- Load [STORE r1,0xA5; OUT r1; JUMP 2] then pulse run → out_valid high exactly once, out_data=0xA5 four cycles after run, then halted=1 with pc=2.
- CALC op 0 with r0=0x35, result to r1, alu_done delayed 3 cycles → alu_start one cycle with a=3, b=5; rf write of alu_res on the alu_done cycle; no write before.
- MEMSTORE addr 9 ← 0x3C, MEMLOAD addr 9 → r2, OUT r2 → out_data=0x3C; mem_re precedes rf_we by one cycle.
- JUMPIF with r0=r1=0x11 jumps to 5; then with r1=0x12 it falls through to pc+1; 8 sequential NOOPs wrap pc 7→0.
- Load 9 words → word 0 equals the 9th word. Assert load during ALU_WAIT → LOAD next cycle, no rf_we, halted=0, lp=0.
- rst_n low for one cycle mid-execution → all outputs at reset values after the edge; prog[] intact (run re-executes the same program).

Source files
------------

// File: rtl/trash_sequencer.sv
// rtl/trash_sequencer.sv - fetch/decode/execute controller for the trash CPU datapath
module trash_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_valid,
   input  logic [14:0] prog_data,
   input  logic        run,
   input  logic        load,
   output logic [1:0]  rf_raddr_a,
   output logic [1:0]  rf_raddr_b,
   input  logic [7:0]  rf_rdata_a,
   input  logic [7:0]  rf_rdata_b,
   output logic        rf_we,
   output logic [1:0]  rf_waddr,
   output logic [7:0]  rf_wdata,
   output logic        alu_start,
   output logic [3:0]  alu_op,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   input  logic        alu_done,
   input  logic [7:0]  alu_res,
   output logic        mem_we,
   output logic        mem_re,
   output logic [3:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic [2:0]  pc,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_LOAD     = 3'd0,
      S_FETCH    = 3'd1,
      S_EXEC     = 3'd2,
      S_ALU_WAIT = 3'd3,
      S_MEM_WB   = 3'd4,
      S_HALT     = 3'd5
   } state_t;

   localparam logic [2:0] OP_NOOP     = 3'd0;
   localparam logic [2:0] OP_STORE    = 3'd1;
   localparam logic [2:0] OP_CALC     = 3'd2;
   localparam logic [2:0] OP_MEMSTORE = 3'd3;
   localparam logic [2:0] OP_MEMLOAD  = 3'd4;
   localparam logic [2:0] OP_JUMP     = 3'd5;
   localparam logic [2:0] OP_JUMPIF   = 3'd6;
   localparam logic [2:0] OP_OUT      = 3'd7;

   state_t      state;
   logic [2:0]  lp;
   logic [14:0] ir;
   logic [14:0] prog [8];

   logic [2:0]  op;
   logic [3:0]  f1;
   logic [3:0]  f2;
   logic [3:0]  f3;
   logic [7:0]  imm;
   logic        branch_taken;
   logic        active;

   assign op  = ir[2:0];
   assign f1  = ir[6:3];
   assign f2  = ir[10:7];
   assign f3  = ir[14:11];
   assign imm = ir[14:7];

   // load and reset squash every datapath strobe so an aborted op never commits
   assign active = rst_n && !load;

   // datapath requests decoded from state and the instruction register
   always_comb begin
      rf_raddr_a   = 2'd0;
      rf_raddr_b   = 2'd0;
      rf_we        = 1'b0;
      rf_waddr     = 2'd0;
      rf_wdata     = 8'h00;
      alu_start    = 1'b0;
      alu_op       = 4'd0;
      alu_a        = 4'd0;
      alu_b        = 4'd0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_addr     = 4'd0;
      mem_wdata    = 8'h00;
      branch_taken = 1'b0;
      if (active) begin
         case (state)
            S_EXEC: begin
               case (op)
                  OP_STORE: begin
                     rf_we    = 1'b1;
                     rf_waddr = f1[1:0];
                     rf_wdata = imm;
                  end
                  OP_CALC: begin
                     rf_raddr_a = f2[1:0];
                     alu_start  = 1'b1;
                     alu_op     = f1;
                     alu_a      = rf_rdata_a[7:4];
                     alu_b      = rf_rdata_a[3:0];
                  end
                  OP_MEMSTORE: begin
                     mem_we    = 1'b1;
                     mem_addr  = f1;
                     mem_wdata = imm;
                  end
                  OP_MEMLOAD: begin
                     mem_re   = 1'b1;
                     mem_addr = f1;
                  end
                  OP_JUMP: begin
                     branch_taken = 1'b1;
                  end
                  OP_JUMPIF: begin
                     rf_raddr_a   = f2[1:0];
                     rf_raddr_b   = f3[1:0];
                     branch_taken = (rf_rdata_a == rf_rdata_b);
                  end
                  OP_OUT: begin
                     rf_raddr_a = f1[1:0];
                  end
                  default: begin
                  end
               endcase
            end
            S_ALU_WAIT: begin
               if (alu_done) begin
                  rf_we    = 1'b1;
                  rf_waddr = f3[1:0];
                  rf_wdata = alu_res;
               end
            end
            S_MEM_WB: begin
               rf_we    = 1'b1;
               rf_waddr = f2[1:0];
               rf_wdata = mem_rdata;
            end
            default: begin
            end
         endcase
      end
   end

   // program store: written only while loading, never cleared by reset
   always_ff @(posedge clk) begin
      if (active && state == S_LOAD && prog_valid) begin
         prog[lp] <= prog_data;
      end
   end

   // sequencer state, program counter, halt flag and registered output port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_LOAD;
         pc        <= 3'd0;
         lp        <= 3'd0;
         ir        <= 15'd0;
         halted    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else begin
         out_valid <= 1'b0;
         if (load) begin
            state  <= S_LOAD;
            lp     <= 3'd0;
            halted <= 1'b0;
         end else begin
            case (state)
               S_LOAD: begin
                  if (prog_valid) begin
                     lp <= lp + 3'd1;
                  end
                  if (run) begin
                     pc    <= 3'd0;
                     state <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  ir    <= prog[pc];
                  state <= S_EXEC;
               end
               S_EXEC: begin
                  case (op)
                     OP_CALC: begin
                        state <= S_ALU_WAIT;
                     end
                     OP_MEMLOAD: begin
                        state <= S_MEM_WB;
                     end
                     OP_JUMP, OP_JUMPIF: begin
                        if (branch_taken && f1[2:0] == pc) begin
                           state  <= S_HALT;
                           halted <= 1'b1;
                        end else if (branch_taken) begin
                           pc    <= f1[2:0];
                           state <= S_FETCH;
                        end else begin
                           pc    <= pc + 3'd1;
                           state <= S_FETCH;
                        end
                     end
                     OP_OUT: begin
                        out_valid <= 1'b1;
                        out_data  <= rf_rdata_a;
                        pc        <= pc + 3'd1;
                        state     <= S_FETCH;
                     end
                     default: begin
                        pc    <= pc + 3'd1;
                        state <= S_FETCH;
                     end
                  endcase
               end
               S_ALU_WAIT: begin
                  if (alu_done) begin
                     pc    <= pc + 3'd1;
                     state <= S_FETCH;
                  end
               end
               S_MEM_WB: begin
                  pc    <= pc + 3'd1;
                  state <= S_FETCH;
               end
               S_HALT: begin
                  state <= S_HALT;
               end
               default: begin
                  state <= S_LOAD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trash_sequencer.sv
// tb/tb_trash_sequencer.sv - directed self-checking bench for trash_sequencer
module tb_trash_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_valid;
   logic [14:0] prog_data;
   logic        run;
   logic        load;
   logic [1:0]  rf_raddr_a;
   logic [1:0]  rf_raddr_b;
   logic [7:0]  rf_rdata_a;
   logic [7:0]  rf_rdata_b;
   logic        rf_we;
   logic [1:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic        alu_start;
   logic [3:0]  alu_op;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic        alu_done;
   logic [7:0]  alu_res;
   logic        mem_we;
   logic        mem_re;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  pc;
   logic        halted;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   trash_sequencer dut (
      .clk(clk), .rst_n(rst_n), .prog_valid(prog_valid), .prog_data(prog_data),
      .run(run), .load(load),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_res(alu_res),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_data(out_data), .pc(pc), .halted(halted)
   );

   // datapath environment: register file, data memory, adder ALU with programmable delay
   logic [7:0] rf [4];
   logic [7:0] dmem [16];
   logic [3:0] alu_cnt = 4'd0;
   logic [7:0] alu_hold = 8'h00;
   logic [3:0] alu_delay = 4'd1;
   logic [3:0] alu_op_seen = 4'd0;

   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];
   assign alu_done   = (alu_cnt == 4'd1);
   assign alu_res    = alu_hold;

   always @(posedge clk) begin
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= dmem[mem_addr];
      if (alu_start) begin
         alu_cnt     <= alu_delay;
         alu_hold    <= {4'h0, alu_a} + {4'h0, alu_b};
         alu_op_seen <= alu_op;
      end else if (alu_cnt != 4'd0) begin
         alu_cnt <= alu_cnt - 4'd1;
      end
   end

   // per-cycle trace of DUT outputs, index i = sampled after the i-th edge following run
   logic       t_ov [64];
   logic [7:0] t_od [64];
   logic       t_we [64];
   logic [1:0] t_wa [64];
   logic [7:0] t_wd [64];
   logic       t_re [64];
   logic       t_mwe [64];
   logic [3:0] t_ma [64];
   logic [7:0] t_mwd [64];
   logic       t_as [64];
   logic [3:0] t_aa [64];
   logic [3:0] t_ab [64];
   logic       t_ht [64];
   logic [2:0] t_pc [64];

   logic [14:0] pbuf [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_prog(input int n);
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < n; i++) begin
         prog_valid = 1'b1;
         prog_data  = pbuf[i];
         tick();
      end
      prog_valid = 1'b0;
   endtask

   task automatic start_run;
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic trace(input int n);
      for (int i = 1; i <= n; i++) begin
         tick();
         t_ov[i] = out_valid;  t_od[i] = out_data;
         t_we[i] = rf_we;      t_wa[i] = rf_waddr;  t_wd[i] = rf_wdata;
         t_re[i] = mem_re;     t_mwe[i] = mem_we;   t_ma[i] = mem_addr;
         t_mwd[i] = mem_wdata; t_as[i] = alu_start; t_aa[i] = alu_a;
         t_ab[i] = alu_b;      t_ht[i] = halted;    t_pc[i] = pc;
      end
   endtask

   function automatic int first_halt(input int n);
      for (int i = 1; i <= n; i++) if (t_ht[i]) return i;
      return -1;
   endfunction

   function automatic int first_ov(input int n);
      for (int i = 1; i <= n; i++) if (t_ov[i]) return i;
      return -1;
   endfunction

   function automatic int count_ov(input int n);
      int c = 0;
      for (int i = 1; i <= n; i++) if (t_ov[i]) c++;
      return c;
   endfunction

   function automatic int count_we(input int n);
      int c = 0;
      for (int i = 1; i <= n; i++) if (t_we[i]) c++;
      return c;
   endfunction

   function automatic int count_as(input int n);
      int c = 0;
      for (int i = 1; i <= n; i++) if (t_as[i]) c++;
      return c;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_pc"},        {29'd0, pc}, 32'd0);
      check({pfx, "_halted"},    {31'd0, halted}, 32'd0);
      check({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({pfx, "_out_data"},  {24'd0, out_data}, 32'h00);
      check({pfx, "_strobes"},   {28'd0, rf_we, mem_we, mem_re, alu_start}, 32'd0);
      check({pfx, "_addrs"},     {20'd0, mem_addr, rf_waddr, rf_raddr_a, rf_raddr_b}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rf[i] = 8'h00;
      for (int i = 0; i < 16; i++) dmem[i] = 8'h00;
      rst_n = 1'b0; prog_valid = 1'b0; prog_data = 15'd0; run = 1'b0; load = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check_reset_outputs("reset");

      // STORE r1,0xA5 ; OUT r1 ; JUMP 2
      pbuf[0] = 15'h5289; pbuf[1] = 15'h000F; pbuf[2] = 15'h0015;
      load_prog(3);
      start_run();
      trace(8);
      check("t1_ov_count", count_ov(8), 1);
      check("t1_ov_cycle", first_ov(8), 4);
      check("t1_out_data", {24'd0, t_od[4]}, 32'hA5);
      check("t1_halt_cycle", first_halt(8), 6);
      check("t1_halt_pc", {29'd0, t_pc[8]}, 32'd2);

      // STORE r0,0x35 ; CALC add r0 -> r1 ; OUT r1 ; JUMP 3, ALU answers 3 cycles after start
      pbuf[0] = 15'h1A81; pbuf[1] = 15'h0802; pbuf[2] = 15'h000F; pbuf[3] = 15'h001D;
      alu_delay = 4'd3;
      load_prog(4);
      start_run();
      trace(14);
      check("t2_alu_start_cnt", count_as(14), 1);
      check("t2_alu_start_cyc", {31'd0, t_as[3]}, 32'd1);
      check("t2_alu_ab", {24'd0, t_aa[3], t_ab[3]}, 32'h35);
      check("t2_alu_op", {28'd0, alu_op_seen}, 32'd0);
      check("t2_no_early_we", {30'd0, t_we[4], t_we[5]}, 32'd0);
      check("t2_wb", {21'd0, t_we[6], t_wa[6], t_wd[6]}, {21'd0, 1'b1, 2'd1, 8'h08});
      check("t2_ov_cycle", first_ov(14), 9);
      check("t2_out_data", {24'd0, t_od[9]}, 32'h08);
      check("t2_halt_cycle", first_halt(14), 11);

      // MEMSTORE [9]<-0x3C ; MEMLOAD [9]->r2 ; OUT r2 ; JUMP 3
      pbuf[0] = 15'h1E4B; pbuf[1] = 15'h014C; pbuf[2] = 15'h0017; pbuf[3] = 15'h001D;
      load_prog(4);
      start_run();
      trace(12);
      check("t3_memstore", {19'd0, t_mwe[1], t_ma[1], t_mwd[1]}, {19'd0, 1'b1, 4'd9, 8'h3C});
      check("t3_mem_re", {30'd0, t_re[3], t_re[4]}, 32'b10);
      check("t3_ma_re", {28'd0, t_ma[3]}, 32'd9);
      check("t3_we_after_re", {21'd0, t_we[3], t_we[4], t_wa[4]}, {21'd0, 1'b0, 1'b1, 2'd2});
      check("t3_wb_data", {24'd0, t_wd[4]}, 32'h3C);
      check("t3_ov_cycle", first_ov(12), 7);
      check("t3_out_data", {24'd0, t_od[7]}, 32'h3C);
      check("t3_halt_cycle", first_halt(12), 9);

      // JUMPIF r0==r1 -> 5 (taken, halts at 5) vs not taken (falls to 3, halts at 3)
      pbuf[0] = 15'h0881; pbuf[1] = 15'h0889; pbuf[2] = 15'h082E;
      pbuf[3] = 15'h001D; pbuf[4] = 15'h0000; pbuf[5] = 15'h002D;
      load_prog(6);
      start_run();
      trace(12);
      check("t4_taken_halt", first_halt(12), 8);
      check("t4_taken_pc", {29'd0, t_pc[12]}, 32'd5);
      pbuf[1] = 15'h0909;
      load_prog(6);
      check("t4_load_clears_halt", {31'd0, halted}, 32'd0);
      start_run();
      trace(12);
      check("t4_fall_halt", first_halt(12), 8);
      check("t4_fall_pc", {29'd0, t_pc[12]}, 32'd3);

      // eight NOOPs: pc steps every two cycles and wraps 7 -> 0
      for (int i = 0; i < 8; i++) pbuf[i] = 15'h0000;
      load_prog(8);
      start_run();
      trace(18);
      check("t5_pc_step", {29'd0, t_pc[2]}, 32'd1);
      check("t5_pc_seven", {29'd0, t_pc[14]}, 32'd7);
      check("t5_pc_wrap", {29'd0, t_pc[16]}, 32'd0);
      check("t5_no_halt", first_halt(18), -1);

      // nine words: the ninth (JUMP 0) replaces word 0, otherwise NOOP;JUMP 1 would halt at 1
      pbuf[0] = 15'h0000; pbuf[1] = 15'h000D;
      for (int i = 2; i < 8; i++) pbuf[i] = 15'h0000;
      pbuf[8] = 15'h0005;
      load_prog(9);
      start_run();
      trace(6);
      check("t6_wrap_halt", first_halt(6), 2);
      check("t6_wrap_pc", {29'd0, t_pc[6]}, 32'd0);

      // load arriving in the same cycle as alu_done abandons the CALC write
      pbuf[0] = 15'h1002; pbuf[1] = 15'h000D;
      alu_delay = 4'd2;
      load_prog(2);
      start_run();
      tick();
      tick();
      tick();
      check("t7_alu_done_seen", {31'd0, alu_done}, 32'd1);
      load = 1'b1;
      #1;
      check("t7_we_squashed", {31'd0, rf_we}, 32'd0);
      tick();
      load = 1'b0;
      trace(6);
      check("t7_no_we_after", count_we(6), 0);
      check("t7_halted_clear", {31'd0, t_ht[6]}, 32'd0);
      check("t7_r2_kept", {24'd0, rf[2]}, 32'h3C);
      prog_valid = 1'b1;
      prog_data  = 15'h0005;
      tick();
      prog_valid = 1'b0;
      start_run();
      trace(6);
      check("t7_lp_zero_halt", first_halt(6), 2);
      check("t7_lp_zero_pc", {29'd0, t_pc[6]}, 32'd0);

      // reset mid-run with out_valid high, then the same program runs again
      pbuf[0] = 15'h5289; pbuf[1] = 15'h000F; pbuf[2] = 15'h0015;
      load_prog(3);
      start_run();
      trace(4);
      check("t8_ov_before_rst", {31'd0, t_ov[4]}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_outputs("t8_rst");
      start_run();
      trace(8);
      check("t8_rerun_ov", first_ov(8), 4);
      check("t8_rerun_data", {24'd0, t_od[4]}, 32'hA5);
      check("t8_rerun_halt", first_halt(8), 6);
      check("t8_rerun_pc", {29'd0, t_pc[8]}, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
